// File: rtl/axis_gpio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_gpio_seq_pkg
// Description : Opcodes, state encoding, status layout and command field
//               helpers shared by the GPIO sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_gpio_seq_pkg;

    // Command word type carried on wuser
    localparam logic c_WUSER_GPIO = 1'b0;
    localparam logic c_WUSER_CTRL = 1'b1;

    // Control word opcodes in bits [31:30]
    localparam logic [1:0] c_OP_DELAY = 2'b00;
    localparam logic [1:0] c_OP_WAIT  = 2'b01;
    localparam logic [1:0] c_OP_SYNC  = 2'b10;
    localparam logic [1:0] c_OP_NOP   = 2'b11;

    // FIFO entry is {wuser, wdata}
    localparam int c_CMD_W = 33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DELAY = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    // Status word bit positions
    localparam int c_STAT_BUSY_BIT  = 31;
    localparam int c_STAT_TMO_BIT   = 30;
    localparam int c_STAT_STATE_LSB = 28;
    localparam int c_STAT_COUNT_W   = 9;

    function automatic logic [1:0] cmd_op(input logic [31:0] w);
        return w[31:30];
    endfunction

    function automatic logic [23:0] cmd_count(input logic [31:0] w);
        return w[23:0];
    endfunction

    function automatic logic [3:0] cmd_pin(input logic [31:0] w);
        return w[27:24];
    endfunction

    function automatic logic cmd_level(input logic [31:0] w);
        return w[28];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seq_cmd_fifo
// Description : Synchronous show-ahead command FIFO with registered fill
//               count and a flush that also drops a same-cycle push.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_gpio_seq.sv
`default_nettype none
// ============================================================================
// Module      : axis_gpio_seq
// Description : Command-driven GPIO sequencer: buffers GPIO and control words,
//               issues GPIO words, delays, waits on input pins, emits SYNC.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_gpio_seq #(
    parameter int CMD_DEPTH = 16,
    parameter int GPI_WIDTH = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          axis_cmd_wdata,
    input  logic                 axis_cmd_wuser,
    input  logic                 axis_cmd_wvalid,
    output logic                 axis_cmd_wready,
    output logic [31:0]          axis_stat_rdata,
    output logic                 axis_stat_rvalid,
    input  logic                 axis_stat_rready,
    output logic [31:0]          gpio_wdata,
    output logic                 gpio_wvalid,
    input  logic                 gpio_wready,
    input  logic [GPI_WIDTH-1:0] gpi_data,
    input  logic                 seq_abort,
    output logic                 seq_event,
    output logic                 seq_busy
);

    import axis_gpio_seq_pkg::*;

    localparam int c_CW = $clog2(CMD_DEPTH) + 1;

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;

    logic [c_CMD_W-1:0]  w_head;
    logic                w_head_user;
    logic [31:0]         w_head_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CW-1:0]     w_fifo_count;

    logic                w_pop;
    logic                w_tmo_evt;
    logic                w_pin;
    logic                w_idx_bad;
    logic [15:0]         w_gpi_pad;
    logic [31:0]         w_status;

    logic [23:0]         r_cnt;
    logic                r_wait_inf;
    logic [3:0]          r_wait_idx;
    logic                r_wait_lvl;
    logic [31:0]         r_gpio_data;
    logic                r_event;
    logic                r_timeout;

    seq_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (c_CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (seq_abort),
        .push      (axis_cmd_wvalid),
        .push_data ({axis_cmd_wuser, axis_cmd_wdata}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign w_head_user = w_head[c_CMD_W-1];
    assign w_head_data = w_head[31:0];

    // Pin index is 4 bits; pad the input bus so any index selects safely
    generate
        if (GPI_WIDTH >= 16) begin : g_gpi_wide
            assign w_gpi_pad = gpi_data[15:0];
        end else begin : g_gpi_narrow
            assign w_gpi_pad = {{(16-GPI_WIDTH){1'b0}}, gpi_data};
        end
    endgenerate

    assign w_pin     = w_gpi_pad[r_wait_idx];
    assign w_idx_bad = ({28'd0, r_wait_idx} >= 32'(GPI_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_user == c_WUSER_GPIO) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        case (cmd_op(w_head_data))
                            c_OP_DELAY: w_state_nxt = ST_DELAY;
                            c_OP_WAIT:  w_state_nxt = ST_WAIT;
                            default:    w_state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                if (gpio_wready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_idx_bad) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_pin == r_wait_lvl) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_wait_inf && r_cnt <= 24'd1) begin
                    w_tmo_evt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (seq_abort) begin
            w_state_nxt = ST_IDLE;
            w_pop       = 1'b0;
            w_tmo_evt   = 1'b0;
        end
    end

    // DELAY loads N-1 so the state lasts N cycles (minimum one);
    // WAIT loads T and times out on the cycle the count reaches one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wait_inf  <= 1'b0;
            r_wait_idx  <= '0;
            r_wait_lvl  <= 1'b0;
            r_gpio_data <= '0;
            r_event     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_event <= w_pop && (w_head_user == c_WUSER_CTRL) &&
                       (cmd_op(w_head_data) == c_OP_SYNC);
            if (w_tmo_evt) begin
                r_timeout <= 1'b1;
            end else if (axis_stat_rready) begin
                r_timeout <= 1'b0;
            end
            if (w_pop) begin
                if (w_head_user == c_WUSER_GPIO) begin
                    r_gpio_data <= w_head_data;
                end else if (cmd_op(w_head_data) == c_OP_DELAY) begin
                    r_cnt <= (cmd_count(w_head_data) == 24'd0) ? 24'd0 :
                             cmd_count(w_head_data) - 24'd1;
                end else if (cmd_op(w_head_data) == c_OP_WAIT) begin
                    r_cnt      <= cmd_count(w_head_data);
                    r_wait_inf <= (cmd_count(w_head_data) == 24'd0);
                    r_wait_idx <= cmd_pin(w_head_data);
                    r_wait_lvl <= cmd_level(w_head_data);
                end
            end else if ((r_state == ST_DELAY || r_state == ST_WAIT) && r_cnt != 24'd0) begin
                r_cnt <= r_cnt - 24'd1;
            end
        end
    end

    always_comb begin
        w_status                                = '0;
        w_status[c_STAT_BUSY_BIT]               = seq_busy;
        w_status[c_STAT_TMO_BIT]                = r_timeout;
        w_status[c_STAT_STATE_LSB +: 2]         = r_state;
        w_status[c_STAT_COUNT_W-1:0]            = 9'(w_fifo_count);
    end

    assign axis_cmd_wready  = ~w_fifo_full;
    assign axis_stat_rdata  = w_status;
    assign axis_stat_rvalid = 1'b1;
    assign gpio_wdata       = r_gpio_data;
    assign gpio_wvalid      = (r_state == ST_ISSUE);
    assign seq_event        = r_event;
    assign seq_busy         = ~w_fifo_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_gpio_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_gpio_seq
// Description : Scoreboard bench for axis_gpio_seq with directed and random
//               command streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_gpio_seq;

    localparam int DEPTH = 16;
    localparam int GW    = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   axis_cmd_wdata = '0;
    logic          axis_cmd_wuser = 1'b0;
    logic          axis_cmd_wvalid = 1'b0;
    logic          axis_cmd_wready;
    logic [31:0]   axis_stat_rdata;
    logic          axis_stat_rvalid;
    logic          axis_stat_rready = 1'b0;
    logic [31:0]   gpio_wdata;
    logic          gpio_wvalid;
    logic          gpio_wready = 1'b0;
    logic [GW-1:0] gpi_data = '0;
    logic          seq_abort = 1'b0;
    logic          seq_event;
    logic          seq_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_mode = 0;

    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    int          ev_cyc[$];

    axis_gpio_seq #(
        .CMD_DEPTH (DEPTH),
        .GPI_WIDTH (GW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .axis_cmd_wdata   (axis_cmd_wdata),
        .axis_cmd_wuser   (axis_cmd_wuser),
        .axis_cmd_wvalid  (axis_cmd_wvalid),
        .axis_cmd_wready  (axis_cmd_wready),
        .axis_stat_rdata  (axis_stat_rdata),
        .axis_stat_rvalid (axis_stat_rvalid),
        .axis_stat_rready (axis_stat_rready),
        .gpio_wdata       (gpio_wdata),
        .gpio_wvalid      (gpio_wvalid),
        .gpio_wready      (gpio_wready),
        .gpi_data         (gpi_data),
        .seq_abort        (seq_abort),
        .seq_event        (seq_event),
        .seq_busy         (seq_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Sink-side ready: 0 = held low, 1 = held high, otherwise random
    initial forever begin
        @(posedge clk);
        #2;
        case (wr_mode)
            0:       gpio_wready = 1'b0;
            1:       gpio_wready = 1'b1;
            default: gpio_wready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the edge following this sample
    always @(negedge clk) begin
        if (!rst) begin
            if (gpio_wvalid && gpio_wready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL gpio_unexpected: actual word=0x%08h required no word", gpio_wdata);
                end else begin
                    check("gpio_word", gpio_wdata, exp_q.pop_front());
                end
            end
            if (seq_event) ev_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic u, input logic [31:0] d, output int hcyc);
        logic ok;
        int   n;
        ok = 1'b0;
        n = 0;
        hcyc = -1;
        axis_cmd_wuser  = u;
        axis_cmd_wdata  = d;
        axis_cmd_wvalid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = axis_cmd_wready;
            if (ok) hcyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        axis_cmd_wvalid = 1'b0;
        check("push_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic push_gpio(input logic [31:0] d);
        int h;
        exp_q.push_back(d);
        push(1'b0, d, h);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (seq_busy && n < lim) begin
            tick(1);
            n++;
        end
        check("idle_reached", {31'd0, seq_busy}, 32'd0);
    endtask

    function automatic logic [31:0] ctl_delay(input int n);
        return {2'b00, 6'd0, 24'(n)};
    endfunction

    function automatic logic [31:0] ctl_wait(input int idx, input logic lvl, input int t);
        return {2'b01, 1'b0, lvl, 4'(idx), 24'(t)};
    endfunction

    initial begin
        int h0;
        int rise;
        int n;
        logic [31:0] d;

        // Reset values
        tick(3);
        rst = 1'b0;
        check("rst_wready", {31'd0, axis_cmd_wready}, 32'd1);
        check("rst_wvalid", {31'd0, gpio_wvalid}, 32'd0);
        check("rst_wdata", gpio_wdata, 32'd0);
        check("rst_event", {31'd0, seq_event}, 32'd0);
        check("rst_busy", {31'd0, seq_busy}, 32'd0);
        check("rst_status", axis_stat_rdata, 32'd0);
        check("rst_rvalid", {31'd0, axis_stat_rvalid}, 32'd1);

        // Two GPIO words back to back, two cycles apart
        wr_mode = 1;
        tick(1);
        hs_cyc.delete();
        push_gpio(32'h0000_8001);
        push_gpio(32'h4000_8001);
        wait_idle(50);
        tick(2);
        check("b2b_count", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2) check("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

        // DELAY 10 then GPIO: valid rises 13 cycles after the DELAY handshake
        push(1'b1, ctl_delay(10), h0);
        push_gpio(32'h1234_5678);
        rise = -1;
        n = 0;
        while (rise < 0 && n < 40) begin
            if (gpio_wvalid) rise = cyc;
            else tick(1);
            n++;
        end
        check("delay_latency", 32'(rise - h0), 32'd13);
        wait_idle(50);

        // WAIT pin 3 high, pin rises at cycle 40
        gpi_data = '0;
        push(1'b1, ctl_wait(3, 1'b1, 100), h0);
        while (cyc < h0 + 40) tick(1);
        check("wait_hold_state", {30'd0, axis_stat_rdata[29:28]}, 32'd3);
        gpi_data[3] = 1'b1;
        tick(1);
        check("wait_match_state", {30'd0, axis_stat_rdata[29:28]}, 32'd0);
        check("wait_match_flag", {31'd0, axis_stat_rdata[30]}, 32'd0);

        // Same wait with the pin low: times out after 100 cycles
        gpi_data = '0;
        push(1'b1, ctl_wait(3, 1'b1, 100), h0);
        while (cyc < h0 + 101) tick(1);
        check("tmo_last_state", {30'd0, axis_stat_rdata[29:28]}, 32'd3);
        check("tmo_flag_early", {31'd0, axis_stat_rdata[30]}, 32'd0);
        tick(1);
        check("tmo_exit_state", {30'd0, axis_stat_rdata[29:28]}, 32'd0);
        check("tmo_flag_set", {31'd0, axis_stat_rdata[30]}, 32'd1);
        axis_stat_rready = 1'b1;
        tick(1);
        axis_stat_rready = 1'b0;
        check("tmo_flag_clear", {31'd0, axis_stat_rdata[30]}, 32'd0);

        // Invalid pin index exits after one cycle with timeout
        push(1'b1, ctl_wait(15, 1'b0, 0), h0);
        tick(2);
        check("badidx_state", {30'd0, axis_stat_rdata[29:28]}, 32'd0);
        check("badidx_flag", {31'd0, axis_stat_rdata[30]}, 32'd1);
        axis_stat_rready = 1'b1;
        tick(1);
        axis_stat_rready = 1'b0;

        // Fill the FIFO behind a long DELAY, then abort
        push(1'b1, ctl_delay(1000), h0);
        tick(2);
        hs_cyc.delete();
        for (int i = 0; i < DEPTH; i++) push(1'b0, 32'hA000_0000 + 32'(i), h0);
        check("full_wready", {31'd0, axis_cmd_wready}, 32'd0);
        check("full_count", {23'd0, axis_stat_rdata[8:0]}, 32'(DEPTH));
        check("full_state", {30'd0, axis_stat_rdata[29:28]}, 32'd2);
        seq_abort = 1'b1;
        tick(1);
        seq_abort = 1'b0;
        check("abort_count", {23'd0, axis_stat_rdata[8:0]}, 32'd0);
        check("abort_state", {30'd0, axis_stat_rdata[29:28]}, 32'd0);
        check("abort_wvalid", {31'd0, gpio_wvalid}, 32'd0);
        check("abort_wready", {31'd0, axis_cmd_wready}, 32'd1);
        tick(30);
        check("abort_no_gpio", 32'(hs_cyc.size()), 32'd0);

        // Stalled GPIO channel: word stable, busy high
        wr_mode = 0;
        tick(1);
        d = $urandom;
        push_gpio(d);
        n = 0;
        while (!gpio_wvalid && n < 20) begin
            tick(1);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_wvalid", {31'd0, gpio_wvalid}, 32'd1);
            check("stall_wdata", gpio_wdata, d);
            check("stall_busy", {31'd0, seq_busy}, 32'd1);
            tick(1);
        end
        wr_mode = 1;
        wait_idle(20);

        // SYNC after a GPIO word
        hs_cyc.delete();
        ev_cyc.delete();
        push_gpio($urandom);
        push(1'b1, 32'h8000_0000, h0);
        wait_idle(50);
        tick(3);
        check("sync_events", 32'(ev_cyc.size()), 32'd1);
        if (ev_cyc.size() == 1 && hs_cyc.size() == 1)
            check("sync_timing", 32'(ev_cyc[0] - hs_cyc[0]), 32'd2);

        // Reset mid-ISSUE discards the word
        wr_mode = 0;
        tick(1);
        push(1'b0, 32'hDEAD_BEEF, h0);
        n = 0;
        while (!gpio_wvalid && n < 20) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("midrst_wvalid", {31'd0, gpio_wvalid}, 32'd0);
        check("midrst_wdata", gpio_wdata, 32'd0);
        check("midrst_busy", {31'd0, seq_busy}, 32'd0);
        wr_mode = 1;
        tick(10);

        // Random command streams against a command-level model
        wr_mode = 2;
        for (int b = 0; b < 4; b++) begin
            int   exp_sync;
            logic exp_tmo;
            exp_sync = 0;
            exp_tmo  = 1'b0;
            gpi_data = GW'($urandom);
            ev_cyc.delete();
            for (int i = 0; i < 25; i++) begin
                int   r;
                int   idx;
                logic lvl;
                r = $urandom_range(0, 9);
                if (r <= 3) begin
                    push_gpio($urandom);
                end else if (r == 4) begin
                    exp_sync++;
                    push(1'b1, 32'h8000_0000 | 32'($urandom_range(0, 255)), h0);
                end else if (r == 5) begin
                    push(1'b1, 32'hC000_0000 | 32'($urandom_range(0, 255)), h0);
                end else if (r == 6) begin
                    push(1'b1, ctl_delay($urandom_range(0, 6)), h0);
                end else begin
                    idx = $urandom_range(0, 15);
                    lvl = 1'($urandom_range(0, 1));
                    if (idx >= GW) exp_tmo = 1'b1;
                    else if (gpi_data[idx] != lvl) exp_tmo = 1'b1;
                    push(1'b1, ctl_wait(idx, lvl, $urandom_range(1, 8)), h0);
                end
            end
            wait_idle(2000);
            tick(2);
            check("rand_gpio_left", 32'(exp_q.size()), 32'd0);
            check("rand_sync_count", 32'(ev_cyc.size()), 32'(exp_sync));
            check("rand_tmo_flag", {31'd0, axis_stat_rdata[30]}, {31'd0, exp_tmo});
            axis_stat_rready = 1'b1;
            tick(1);
            axis_stat_rready = 1'b0;
            exp_q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
